// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter: instruction fetch and load/store unit
// share one memory port. One transaction in flight, round-robin between
// requesters, byte-lane store formatting, load extraction and a timeout
// that turns a stuck access into an error completion.
//
// state  | meaning
// S_IDLE | no transaction, combinational grant to a requester
// S_REQ  | mem_req asserted, waiting for mem_ready
// S_WAIT | request accepted, waiting for mem_rvalid
// S_RESP | one-cycle completion pulse to the owner
module mem_bus_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        ls_req_i,
    input  logic        ls_we_i,
    input  logic        ls_unsigned_i,
    input  logic [1:0]  ls_size_i,
    input  logic [31:0] ls_addr_i,
    input  logic [31:0] ls_wdata_i,
    output logic        ls_gnt_o,
    output logic        ls_rvalid_o,
    output logic        ls_err_o,
    output logic [31:0] ls_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic        mem_ready_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

    state_e        state_q, state_d;
    logic          owner_ls_q, prio_if_q, we_q, uns_q, err_q;
    logic [1:0]    size_q;
    logic [31:0]   addr_q, wdata_q, rdata_q;
    logic [3:0]    wstrb_q;
    logic [CW-1:0] cnt_q;

    logic          grant_ls, grant_if, misaligned, timeout_hit;
    logic [31:0]   st_wdata, load_ext;
    logic [3:0]    st_wstrb;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;

    assign misaligned  = ((ls_size_i == 2'd1) && ls_addr_i[0]) ||
                         (ls_size_i[1] && (ls_addr_i[1:0] != 2'b00));
    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
    assign if_gnt_o    = grant_if;
    assign ls_gnt_o    = grant_ls;

    // Round-robin grant, only in IDLE; held low while reset is asserted
    always_comb begin
        grant_ls = 1'b0;
        grant_if = 1'b0;
        if ((state_q == S_IDLE) && !rst_i) begin
            if (ls_req_i && (!if_req_i || !prio_if_q)) grant_ls = 1'b1;
            else if (if_req_i)                         grant_if = 1'b1;
        end
    end

    // Store lane replication and byte strobes from the LSU request
    always_comb begin
        case (ls_size_i)
            2'd0: begin
                st_wdata = {4{ls_wdata_i[7:0]}};
                st_wstrb = 4'b0001 << ls_addr_i[1:0];
            end
            2'd1: begin
                st_wdata = {2{ls_wdata_i[15:0]}};
                st_wstrb = 4'b0011 << ls_addr_i[1:0];
            end
            default: begin
                st_wdata = ls_wdata_i;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    // Load lane extraction and sign/zero extension of the captured word
    always_comb begin
        ld_byte  = 8'(rdata_q >> {addr_q[1:0], 3'b000});
        ld_half  = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (size_q)
            2'd0:    load_ext = uns_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'd1:    load_ext = uns_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: load_ext = rdata_q;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state; a response in the timeout cycle still completes normally
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (grant_ls && misaligned)  state_d = S_RESP;
                else if (grant_ls || grant_if) state_d = S_REQ;
            end
            S_REQ: begin
                if (timeout_hit)      state_d = S_RESP;
                else if (mem_ready_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rvalid_i || timeout_hit) state_d = S_RESP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Transaction registers: latched at grant, updated while in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_ls_q <= 1'b0;
            prio_if_q  <= 1'b0;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            err_q      <= 1'b0;
            size_q     <= 2'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
            cnt_q      <= '0;
        end else if (grant_ls || grant_if) begin
            owner_ls_q <= grant_ls;
            prio_if_q  <= grant_ls;
            err_q      <= grant_ls && misaligned;
            rdata_q    <= '0;
            cnt_q      <= '0;
            if (grant_ls) begin
                addr_q  <= ls_addr_i;
                size_q  <= ls_size_i;
                we_q    <= ls_we_i;
                uns_q   <= ls_unsigned_i;
                wdata_q <= ls_we_i ? st_wdata : 32'b0;
                wstrb_q <= ls_we_i ? st_wstrb : 4'b0;
            end else begin
                addr_q  <= if_addr_i;
                size_q  <= 2'd2;
                we_q    <= 1'b0;
                uns_q   <= 1'b0;
                wdata_q <= '0;
                wstrb_q <= '0;
            end
        end else if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
            cnt_q <= cnt_q + CW'(1);
            if ((state_q == S_WAIT) && mem_rvalid_i) rdata_q <= mem_rdata_i;
            else if (timeout_hit)                    err_q   <= 1'b1;
        end
    end

    // FSM outputs: memory request in REQ, owner completion in RESP
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wstrb_o = '0;
        ls_rvalid_o = 1'b0;
        ls_err_o    = 1'b0;
        ls_rdata_o  = '0;
        if_rvalid_o = 1'b0;
        if_rdata_o  = '0;
        case (state_q)
            S_REQ: begin
                mem_req_o   = 1'b1;
                mem_we_o    = we_q;
                mem_addr_o  = {addr_q[31:2], 2'b00};
                mem_wdata_o = wdata_q;
                mem_wstrb_o = wstrb_q;
            end
            S_RESP: begin
                if (owner_ls_q) begin
                    ls_rvalid_o = 1'b1;
                    ls_err_o    = err_q;
                    ls_rdata_o  = (err_q || we_q) ? 32'b0 : load_ext;
                end else begin
                    if_rvalid_o = 1'b1;
                    if_rdata_o  = err_q ? 32'b0 : rdata_q;
                end
            end
            default: ;
        endcase
    end

endmodule
